// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: two requesters share one 4-bit logical unit through a
// round-robin grant. The accepted op is registered and presented to the unit
// for one cycle. The unit's result is captured and then returned with the ID of
// the requester that issued it.
//
// Handshake: a transfer happens on a port in any cycle where that port's
// valid and ready are both high at the rising edge. A producer holds valid and
// its payload until the transfer. Ready never depends on anything except state
// and the request valids, and at most one req ready is high at a time.
module logic_unit_arbiter #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  output logic [1:0]        alu_sel,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [RES_W-1:0]  alu_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [RES_W-1:0]  resp_result,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;      // requester favoured when both are valid
  logic   grant;     // requester that would be accepted this cycle
  logic   any_valid;

  // Grant selection: a lone valid requester wins, a tie goes to prio.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && any_valid && !grant;
  assign req1_ready = (state == IDLE) && any_valid && grant;
  assign state_dbg  = state;

  // Arbitration FSM: accept, drive the logical unit one cycle, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      alu_sel     <= 2'b00;
      alu_x       <= '0;
      alu_y       <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_sel <= grant ? req1_sel : req0_sel;
            alu_x   <= grant ? req1_x   : req0_x;
            alu_y   <= grant ? req1_y   : req0_y;
            resp_id <= grant;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // alu_* have been stable since the accept edge, so the unit's
          // combinational output is settled here.
          resp_result <= alu_result;
          resp_valid  <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            prio       <= ~resp_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: the logical unit is modelled
// combinationally, and a transaction-level reference model checks every cycle
// against a scoreboard of expected responses.
module tb_logic_unit_arbiter;

  localparam int DATA_W = 4;
  localparam int RES_W  = 9;
  localparam int EW     = 1 + RES_W + 2 + 2 * DATA_W; // {id, result, sel, x, y}

  logic              clk;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [1:0]        req0_sel, req1_sel;
  logic [DATA_W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [1:0]        alu_sel;
  logic [DATA_W-1:0] alu_x, alu_y;
  logic [RES_W-1:0]  alu_result;
  logic              resp_valid, resp_ready, resp_id;
  logic [RES_W-1:0]  resp_result;
  logic              busy;
  logic [1:0]        state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [EW-1:0] exp_q[$];
  int            m_pending = 0;
  int            m_age     = 0;
  logic          m_prio    = 1'b0;
  int            wait0 = 0, wait1 = 0;
  logic          last_acc0 = 1'b0, last_acc1 = 1'b0;

  // Logical unit behaviour: 4-bit AND/OR/XOR, or NOT of the 8-bit {x,y}.
  function automatic logic [RES_W-1:0] lu_ref(logic [1:0] sel, logic [DATA_W-1:0] x,
                                               logic [DATA_W-1:0] y);
    case (sel)
      2'd0:    return {5'b0, x & y};
      2'd1:    return {5'b0, x | y};
      2'd2:    return {5'b0, x ^ y};
      default: return {1'b0, ~{x, y}};
    endcase
  endfunction

  assign alu_result = lu_ref(alu_sel, alu_x, alu_y);

  logic_unit_arbiter #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_x(req1_x), .req1_y(req1_y),
    .alu_sel(alu_sel), .alu_x(alu_x), .alu_y(alu_y), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic          e_g, e_r0, e_r1;
    logic [EW-1:0] ent;
    last_acc0 = 1'b0;
    last_acc1 = 1'b0;
    if (reset) begin
      check_eq("rst_resp_valid", resp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_alu_x", alu_x, 0);
      exp_q.delete();
      m_pending = 0;
      m_age     = 0;
      m_prio    = 1'b0;
      wait0     = 0;
      wait1     = 0;
    end else if (m_pending == 0) begin
      e_g  = (req0_valid && req1_valid) ? m_prio : req1_valid;
      e_r0 = (req0_valid || req1_valid) && !e_g;
      e_r1 = (req0_valid || req1_valid) && e_g;
      check_eq("idle_req0_ready", req0_ready, e_r0);
      check_eq("idle_req1_ready", req1_ready, e_r1);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_resp_valid", resp_valid, 0);
      if (e_r0 || e_r1) begin
        if (e_g) begin
          ent = {1'b1, lu_ref(req1_sel, req1_x, req1_y), req1_sel, req1_x, req1_y};
          check_eq("starve1", (wait1 <= 1), 1);
          wait1 = 0;
          if (req0_valid) wait0++;
        end else begin
          ent = {1'b0, lu_ref(req0_sel, req0_x, req0_y), req0_sel, req0_x, req0_y};
          check_eq("starve0", (wait0 <= 1), 1);
          wait0 = 0;
          if (req1_valid) wait1++;
        end
        exp_q.push_back(ent);
        m_pending = 1;
        m_age     = 0;
        last_acc0 = !e_g;
        last_acc1 = e_g;
      end
    end else begin
      m_age++;
      ent = exp_q[0];
      check_eq("busy_req0_ready", req0_ready, 0);
      check_eq("busy_req1_ready", req1_ready, 0);
      check_eq("busy_flag", busy, 1);
      if (m_age == 1) begin
        check_eq("exec_resp_valid", resp_valid, 0);
        check_eq("exec_alu_sel", alu_sel, ent[9:8]);
        check_eq("exec_alu_x", alu_x, ent[7:4]);
        check_eq("exec_alu_y", alu_y, ent[3:0]);
      end else begin
        check_eq("resp_valid", resp_valid, 1);
        check_eq("resp_id", resp_id, ent[EW-1]);
        check_eq("resp_result", resp_result, ent[EW-2:EW-1-RES_W]);
        if (resp_ready) begin
          void'(exp_q.pop_front());
          m_prio    = ~ent[EW-1];
          m_pending = 0;
        end
      end
    end
  end

  // Driver tasks
  task automatic set_req(input int id, input logic [1:0] sel, input logic [3:0] x,
                         input logic [3:0] y);
    if (id == 0) begin
      req0_valid = 1'b1; req0_sel = sel; req0_x = x; req0_y = y;
    end else begin
      req1_valid = 1'b1; req1_sel = sel; req1_x = x; req1_y = y;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_accept(input int id);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if ((id == 0 && req0_valid && req0_ready) || (id == 1 && req1_valid && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("accept_timeout", 1, 0);
  endtask

  task automatic wait_resp(output logic id, output logic [RES_W-1:0] res, output int cyc);
    logic ok;
    ok = 1'b0; id = 1'b0; res = '0; cyc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        id  = resp_id;
        res = resp_result;
        cyc = k + 1;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("resp_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (last_acc0) req0_valid = 1'b0;
      if (last_acc1) req1_valid = 1'b0;
      resp_ready = 1'b1;
      if (!req0_valid && !req1_valid && m_pending == 0) break;
    end
    @(negedge clk);
    check_eq("drain_idle", busy, 0);
  endtask

  // Stimulus
  initial begin
    logic             r_id;
    logic [RES_W-1:0] r_res;
    int               cyc;
    int               seen;

    reset = 1'b1;
    req0_valid = 1'b0; req0_sel = 2'd0; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_sel = 2'd0; req1_x = '0; req1_y = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", state_dbg, 0);
    check_eq("reset_resp_id", resp_id, 0);
    check_eq("reset_resp_result", resp_result, 0);
    check_eq("reset_alu_sel", alu_sel, 0);
    check_eq("reset_alu_y", alu_y, 0);
    #2 reset = 1'b0;

    // Reset while the op is in EXEC: it must never respond.
    @(posedge clk); #1;
    set_req(0, 2'd2, 4'h3, 4'h5);
    resp_ready = 1'b1;
    wait_accept(0);
    @(posedge clk); #1;
    check_eq("t1_in_exec", state_dbg, 1);
    reset = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_resp_valid", resp_valid, 0);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_state", state_dbg, 0);
    #2 reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check_eq("t1_no_resp", seen, 0);

    // req0 alone, AND C,A.
    @(posedge clk); #1;
    set_req(0, 2'd0, 4'hC, 4'hA);
    @(negedge clk);
    check_eq("t2_req0_ready", req0_ready, 1);
    check_eq("t2_req1_ready", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(r_id, r_res, cyc);
    check_eq("t2_latency", cyc, 2);
    check_eq("t2_result", r_res, 9'h008);
    check_eq("t2_id", r_id, 0);

    // Both valid from reset: req0 first, then req1.
    pulse_reset();
    @(posedge clk); #1;
    set_req(0, 2'd1, 4'hC, 4'hA);
    set_req(1, 2'd2, 4'hC, 4'hA);
    resp_ready = 1'b1;
    wait_accept(0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(r_id, r_res, cyc);
    check_eq("t3_first_id", r_id, 0);
    check_eq("t3_first_res", r_res, 9'h00E);
    wait_accept(1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(r_id, r_res, cyc);
    check_eq("t3_second_id", r_id, 1);
    check_eq("t3_second_res", r_res, 9'h006);

    // Both held continuously: grants alternate starting with req0.
    @(posedge clk); #1;
    set_req(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    set_req(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 6; i++) begin
      wait_resp(r_id, r_res, cyc);
      check_eq("t4_grant_order", r_id, 16'(i % 2));
      check_eq("t4_result", r_res, (i % 2 == 1) ? lu_ref(req1_sel, req1_x, req1_y)
                                                 : lu_ref(req0_sel, req0_x, req0_y));
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // req1 NOT F,0 with a stalled consumer; req0 waits and changes x meanwhile.
    @(posedge clk); #1;
    set_req(1, 2'd3, 4'hF, 4'h0);
    resp_ready = 1'b0;
    wait_accept(1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    set_req(0, 2'd1, 4'h1, 4'h0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        break;
      end
    end
    check_eq("t5_resp_seen", seen, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_hold_result", resp_result, 9'h00F);
      check_eq("t5_hold_valid", resp_valid, 1);
      check_eq("t5_hold_id", resp_id, 1);
      check_eq("t5_busy", busy, 1);
      check_eq("t5_req0_blocked", req0_ready, 0);
      @(posedge clk); #1;
      if (i == 1) req0_x = 4'h5;
      if (i == 3) resp_ready = 1'b1;
      else @(negedge clk);
    end
    wait_resp(r_id, r_res, cyc);
    check_eq("t5_result", r_res, 9'h00F);
    wait_accept(0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_alu_x", alu_x, 4'h5);
    wait_resp(r_id, r_res, cyc);
    check_eq("t6_result", r_res, 9'h005);
    check_eq("t6_id", r_id, 0);

    // Randomized traffic; the reference model checks every cycle.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (last_acc0 || !req0_valid) begin
        if ($urandom_range(0, 2) != 0)
          set_req(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else
          req0_valid = 1'b0;
      end
      if (last_acc1 || !req1_valid) begin
        if ($urandom_range(0, 2) != 0)
          set_req(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else
          req1_valid = 1'b0;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
